// File: rtl/sobel_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sobel_frame_ctrl                                                           |
// | Raster-scans one zero-padded frame into the sobel datapath and tags each   |
// | Gx/Gy result with valid, image coordinates and a linear result address.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sobel_frame_ctrl #(
  parameter int IMG_W  = 480,
  parameter int IMG_H  = 480,
  parameter int ADDR_W = 18,
  parameter int CW     = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [7:0]        mem_rd_data,
  output logic [7:0]        pix_out,
  output logic              sobel_start,
  output logic              res_valid,
  output logic [CW-1:0]     res_x,
  output logic [CW-1:0]     res_y,
  output logic [ADDR_W-1:0] res_addr
);

  localparam int PW  = IMG_W + 2;
  localparam int PH  = IMG_H + 2;
  localparam int RW  = $clog2(PH);
  localparam int CCW = $clog2(PW);

  localparam logic [RW-1:0]  R_LAST = RW'(PH - 1);
  localparam logic [CCW-1:0] C_LAST = CCW'(PW - 1);
  localparam logic [RW-1:0]  R_ONE  = RW'(1);
  localparam logic [RW-1:0]  R_TWO  = RW'(2);
  localparam logic [RW-1:0]  R_HI   = RW'(IMG_H);
  localparam logic [CCW-1:0] C_ONE  = CCW'(1);
  localparam logic [CCW-1:0] C_TWO  = CCW'(2);
  localparam logic [CCW-1:0] C_HI   = CCW'(IMG_W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_n;

  logic              w_load;
  logic              w_adv;
  logic              w_issue;
  logic              w_kill;
  logic [RW-1:0]     r_row, w_row_n;
  logic [CCW-1:0]    r_col, w_col_n;
  logic [1:0]        r_drain;
  logic              w_int;
  logic              w_start;
  logic [CW-1:0]     w_x;
  logic [CW-1:0]     w_y;

  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W-1:0] r_res_cnt;
  logic              r_start0;
  logic [CW-1:0]     r_x0, r_y0;
  logic              r_int1, r_start1;
  logic [CW-1:0]     r_x1, r_y1;
  logic [CW-1:0]     r_x2, r_y2;

  assign busy    = (state == S_RUN) || (state == S_DRAIN);
  assign done    = (state == S_DONE);
  assign w_issue = w_load || w_adv;
  assign w_kill  = abort && busy;

  always_comb begin
    state_n = state;
    w_load  = 1'b0;
    w_adv   = 1'b0;
    case (state)
      S_IDLE: begin
        if (go && !abort) begin
          state_n = S_RUN;
          w_load  = 1'b1;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_n = S_IDLE;
        end else if (r_row == R_LAST && r_col == C_LAST) begin
          state_n = S_DRAIN;
        end else begin
          w_adv = 1'b1;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_n = S_IDLE;
        end else if (r_drain == 2'd2) begin
          state_n = S_DONE;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Next padded index; stage 0 is registered from this so index k lands at g+k.
  always_comb begin
    w_row_n = r_row;
    w_col_n = r_col;
    if (w_load) begin
      w_row_n = '0;
      w_col_n = '0;
    end else if (w_adv) begin
      if (r_col == C_LAST) begin
        w_col_n = '0;
        w_row_n = r_row + 1'b1;
      end else begin
        w_col_n = r_col + 1'b1;
      end
    end
  end

  assign w_int   = w_issue && (w_row_n >= R_ONE) && (w_row_n <= R_HI) &&
                   (w_col_n >= C_ONE) && (w_col_n <= C_HI);
  assign w_start = w_issue && (w_row_n >= R_TWO) && (w_col_n >= C_TWO);
  assign w_x     = CW'(w_col_n - C_TWO);
  assign w_y     = CW'(w_row_n - R_TWO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_drain <= 2'd0;
    end else begin
      state   <= state_n;
      r_row   <= w_row_n;
      r_col   <= w_col_n;
      r_drain <= (state == S_DRAIN) ? r_drain + 2'd1 : 2'd0;
    end
  end

  // Stage 0: read strobe. Reads happen in raster order, so the address is a running count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      r_rd_ptr    <= '0;
      r_start0    <= 1'b0;
      r_x0        <= '0;
      r_y0        <= '0;
    end else begin
      mem_rd_en <= w_int;
      r_start0  <= w_start;
      if (w_load) begin
        r_rd_ptr <= '0;
      end
      if (w_int) begin
        mem_rd_addr <= r_rd_ptr;
        r_rd_ptr    <= r_rd_ptr + 1'b1;
      end
      if (w_start) begin
        r_x0 <= w_x;
        r_y0 <= w_y;
      end
    end
  end

  // Stage 1: memory latency slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_int1   <= 1'b0;
      r_start1 <= 1'b0;
      r_x1     <= '0;
      r_y1     <= '0;
    end else begin
      r_int1   <= w_kill ? 1'b0 : mem_rd_en;
      r_start1 <= w_kill ? 1'b0 : r_start0;
      r_x1     <= r_x0;
      r_y1     <= r_y0;
    end
  end

  // Stage 2: padded pixel and window-valid to the datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_out     <= 8'd0;
      sobel_start <= 1'b0;
      r_x2        <= '0;
      r_y2        <= '0;
    end else begin
      pix_out     <= (w_kill || !r_int1) ? 8'd0 : mem_rd_data;
      sobel_start <= w_kill ? 1'b0 : r_start1;
      r_x2        <= r_x1;
      r_y2        <= r_y1;
    end
  end

  // Stage 3: results emerge in raster order, so res_addr is a running count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_x     <= '0;
      res_y     <= '0;
      res_addr  <= '0;
      r_res_cnt <= '0;
    end else begin
      res_valid <= w_kill ? 1'b0 : sobel_start;
      if (w_load) begin
        r_res_cnt <= '0;
      end
      if (!w_kill && sobel_start) begin
        res_x     <= r_x2;
        res_y     <= r_y2;
        res_addr  <= r_res_cnt;
        r_res_cnt <= r_res_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/sobel_frame_ctrl.md
# sobel_frame_ctrl

Frame sequencer for the `sobel` edge datapath. On a `go` pulse it raster-scans one IMG_W x IMG_H 8-bit image from a synchronous frame memory and inserts the one-pixel zero border the datapath's line pitch expects. It streams exactly one padded pixel per cycle into `sobel.in` and drives `sobel.start` only when the 3x3 window is fully inside the padded frame. It also tags each `Gxout`/`Gyout` result with a valid strobe, image coordinates and a linear result address for the result-memory writer.

## Interface
- IMG_W, 480, image width; padded pitch PW = IMG_W+2 must equal the datapath line pitch (482)
- IMG_H, 480, image height; padded height PH = IMG_H+2
- ADDR_W, 18, frame/result memory address width (IMG_W*IMG_H <= 2^ADDR_W)
- CW, 9, width of coordinate outputs
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- go  in  1  start-of-frame request, sampled in IDLE
- abort  in  1  synchronous frame cancel
- busy  out  1  high while a frame is in flight
- done  out  1  one-cycle pulse after the last result
- mem_rd_en  out  1  frame-memory read strobe (registered)
- mem_rd_addr  out  ADDR_W  read address = y*IMG_W + x (registered)
- mem_rd_data  in  8  read data, valid the cycle after mem_rd_en
- pix_out  out  8  padded pixel to `sobel.in` (registered)
- sobel_start  out  1  to `sobel.start`, window-valid for current pix_out
- res_valid  out  1  `Gxout`/`Gyout` hold a real result this cycle
- res_x, res_y  out  CW  image coordinates of that result
- res_addr  out  ADDR_W  res_y*IMG_W + res_x

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: `go`=1 and `abort`=0 goes to RUN. Padded index k=0 is loaded as row R=0, column C=0.
- RUN: k advances by 1 every cycle, with no stalls. C wraps at PW-1 and R increments on the wrap. Leave RUN after k = PW*PH-1 and go to DRAIN.
- DRAIN: lasts 3 cycles and empties the pipeline, then goes to DONE.
- DONE: lasts one cycle with `done`=1, then goes to IDLE.
- Interior test: index k is interior iff 1<=R<=IMG_H and 1<=C<=IMG_W.
  - Interior: issue a read at image (R-1, C-1).
  - Border: no read (mem_rd_en=0), and the pipeline carries a zero flag.
- Pixel path:
  - Stage 0 registers mem_rd_en, mem_rd_addr and the interior flag.
  - Stage 1 waits one cycle for memory.
  - Stage 2 registers pix_out = interior ? mem_rd_data : 0.
- sobel_start is registered alongside pix_out. It is 1 iff R>=2 and C>=2 for that k.
- The datapath computes the window on the following negedge and registers it on the next posedge.
- res_valid is sobel_start delayed one cycle. res_x = C-2 and res_y = R-2 are carried down the same pipeline.
- Results per frame: exactly IMG_W*IMG_H res_valid cycles, in raster order.
  - Per padded row, res_valid is low for 2 cycles (C=0,1).
  - res_valid stays low entirely for padded rows 0 and 1.
- No linebuffer flush is needed. The first valid window (k = 2*PW+2 = 966) already spans only current-frame data.
- `go` while busy is ignored. `abort` in IDLE is ignored. `abort`+`go` in IDLE: abort wins.
- Abort while busy: on that edge go to IDLE and clear mem_rd_en, pix_out, sobel_start and res_valid. `done` is not pulsed.
- A new `go` is accepted in the cycle after DONE.

## Timing
- Reset values: busy=0, done=0, mem_rd_en=0, mem_rd_addr=0, pix_out=0, sobel_start=0, res_valid=0, res_x=0, res_y=0, res_addr=0. State is IDLE.
- Let g = the posedge sampling `go`. Let N = PW*PH (232324 at defaults).
- busy rises at g and falls at g+N+3.
- Read strobe for index k is registered at g+k.
- pix_out and sobel_start for index k are registered at g+k+2.
- res_valid and coordinates for index k are registered at g+k+3.
- First res_valid: g+2*PW+5 (g+969 at defaults), with (x,y)=(0,0), addr 0.
- Last res_valid: g+N+2, with (IMG_W-1, IMG_H-1), addr IMG_W*IMG_H-1.
- done=1 during the cycle after g+N+3 only.
- Throughput: one padded pixel per cycle, which is mandatory because the datapath linebuffer shifts every cycle.

## Test plan
- Reset mid-RUN (rst asserted asynchronously): every output reaches its reset value without waiting for a clock edge. After release, `go` starts a clean frame.
- Defaults, ramp image (pixel = (x+y)&0xFF) through `sobel`:
  - exactly 230400 res_valid pulses; first at g+969 with addr 0, last at g+232326 with addr 230399;
  - `done` at g+232327;
  - Gx/Gy thresholds match the golden model with zero padding.
- IMG_W=4, IMG_H=3 standalone: pix_out sequence is 6 zeros, 0,a,b,c,d,0 per image row, then 6 zeros (N=30). sobel_start is high at k=14..17, 20..23, 26..29.
- Abort at g+500: at that edge pix_out=0 and sobel_start=0. No res_valid and no done follow. busy=0 next cycle.
- `go` held high through a frame: second frame starts exactly one cycle after done. `go` pulses during RUN have no effect.
- Uniform image 0xFF: border-column results give Gx=255 on res_x=0 only where the threshold trips. Interior results are Gx=Gy=0.
